aes_128_enc: RTL and testbench



---
 rtl/aes_128_enc.sv | 171 +++++++++++++++++
 tb/tb_aes_128_enc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_enc.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_enc
// Brief    : Fully pipelined AES-128 encryptor with on-the-fly key expansion,
//            one block per clock, 11-cycle latency. Define AES_OUT_VALID_EN to
//            add in_valid/out_valid tracking.
// Revision : 1.0
// ============================================================================
module aes_128_enc (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] state,
   input  logic [127:0] key,
`ifdef AES_OUT_VALID_EN
   input  logic         in_valid,
   output logic         out_valid,
`endif
   output logic [127:0] out
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse computed as x^254 (maps 0 to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240, x252, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = x15;
      for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
      x252 = gf_mul(x240, x12);
      inv  = gf_mul(x252, x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   // Row r of the output column c comes from input column (c + r) mod 4.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
      n0 = k[127:96] ^ t;
      n1 = k[95:64]  ^ n0;
      n2 = k[63:32]  ^ n1;
      n3 = w3        ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [7:0] rcon(input int i);
      logic [7:0] rc;
      case (i)
         1:       rc = 8'h01;
         2:       rc = 8'h02;
         3:       rc = 8'h04;
         4:       rc = 8'h08;
         5:       rc = 8'h10;
         6:       rc = 8'h20;
         7:       rc = 8'h40;
         8:       rc = 8'h80;
         9:       rc = 8'h1b;
         default: rc = 8'h36;
      endcase
      return rc;
   endfunction

   logic [127:0] s_d [0:10];
   logic [127:0] s_q [0:10];
   logic [127:0] k_d [0:9];
   logic [127:0] k_q [0:9];
   logic [127:0] rk  [1:10];
   logic [127:0] out_d, out_q;

   always_comb begin
      s_d[0] = state ^ key;
      k_d[0] = key;
      for (int i = 1; i <= 10; i++) begin
         rk[i] = key_expand(k_q[i-1], rcon(i));
         if (i < 10) begin
            k_d[i] = rk[i];
            s_d[i] = mix_columns(shift_rows(sub_bytes(s_q[i-1]))) ^ rk[i];
         end else begin
            s_d[i] = shift_rows(sub_bytes(s_q[i-1])) ^ rk[i];
         end
      end
      out_d = s_q[10];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= 10; i++) s_q[i] <= '0;
         for (int i = 0; i <= 9; i++)  k_q[i] <= '0;
         out_q <= '0;
      end else begin
         for (int i = 0; i <= 10; i++) s_q[i] <= s_d[i];
         for (int i = 0; i <= 9; i++)  k_q[i] <= k_d[i];
         out_q <= out_d;
      end
   end

   assign out = out_q;

`ifdef AES_OUT_VALID_EN
   // Valid bits ride alongside s_q[0..10]; the final flop aligns with out_q.
   logic [10:0] valid_d, valid_q;
   logic        out_valid_d, out_valid_q;

   always_comb begin
      valid_d     = {valid_q[9:0], in_valid};
      out_valid_d = valid_q[10];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_128_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_enc
// Brief    : Self-checking bench for aes_128_enc against a byte-level AES model.
// Revision : 1.0
// ============================================================================
module tb_aes_128_enc;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] state;
   logic [127:0] key;
   logic [127:0] out;
   logic         in_valid;
`ifdef AES_OUT_VALID_EN
   logic         out_valid;
`endif

   always #10 clk = ~clk;

   aes_128_enc dut (
      .clk      (clk),
      .rst      (rst),
      .state    (state),
      .key      (key),
`ifdef AES_OUT_VALID_EN
      .in_valid (in_valid),
      .out_valid(out_valid),
`endif
      .out      (out)
   );

   int           tests = 0;
   int           fails = 0;
   int           cyc   = 0;
   logic [7:0]   sbox_t [256];
   logic [127:0] exp_ct [0:1023];
   logic         h_rst  [0:1023];
   logic         h_iv   [0:1023];
   logic [127:0] cur_exp;

   function automatic int gmul(input int a, input int b);
      int r;
      r = 0;
      while (b != 0) begin
         if ((b & 1) != 0) r = r ^ a;
         a = a << 1;
         if ((a & 256) != 0) a = a ^ 'h11b;
         b = b >> 1;
      end
      return r;
   endfunction

   // Classic table generation: walk the multiplicative group with generator 3.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if ((q & 8'h80) != 0) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc  = 8'(gmul(int'(rc), 2));
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         for (int i = 0; i < 16; i++) s[i] = t[i];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  t[4*c+r] = 8'(gmul(int'(s[4*c+r]), 2) ^ gmul(int'(s[4*c+(r+1)%4]), 3)
                                ^ int'(s[4*c+(r+2)%4]) ^ int'(s[4*c+(r+3)%4]));
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // One clock: record what the DUT sampled, then check out 1 time unit later.
   task automatic tick();
      logic clean;
      logic exp_v;
      @(posedge clk);
      h_rst[cyc]  = rst;
      h_iv[cyc]   = in_valid;
      exp_ct[cyc] = cur_exp;
      #1;
      clean = (cyc >= 11);
      if (clean)
         for (int j = cyc - 11; j <= cyc; j++) if (h_rst[j]) clean = 1'b0;
      exp_v = 1'b0;
      if (clean) exp_v = h_iv[cyc-11];
      if (rst) begin
         tests++;
         assert (out === 128'h0) else begin
            fails++;
            $error("FAIL reset_out cyc=%0d: observed %h expected %h", cyc, out, 128'h0);
         end
      end else if (clean) begin
         tests++;
         assert (out === exp_ct[cyc-11]) else begin
            fails++;
            $error("FAIL ciphertext cyc=%0d: observed %h expected %h", cyc, out, exp_ct[cyc-11]);
         end
      end
`ifdef AES_OUT_VALID_EN
      if (rst || clean) begin
         tests++;
         assert (out_valid === exp_v) else begin
            fails++;
            $error("FAIL out_valid cyc=%0d: observed %b expected %b", cyc, out_valid, exp_v);
         end
      end
`endif
      cyc++;
   endtask

   task automatic drive(input logic [127:0] k, input logic [127:0] p, input logic v);
      key      = k;
      state    = p;
      in_valid = v;
      cur_exp  = aes_ref(k, p);
      tick();
   endtask

   task automatic drive_kat(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ct);
      key      = k;
      state    = p;
      in_valid = 1'b1;
      cur_exp  = ct;
      tick();
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_AB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_AB  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_AB  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_ZZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      build_sbox();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) drive(rnd128(), rnd128(), 1'b1);
      rst = 1'b0;

      // Known-answer vectors back to back, then random streaming traffic.
      drive_kat(K_C1, P_C1, C_C1);
      drive_kat(K_AB, P_AB, C_AB);
      drive_kat(128'h0, 128'h0, C_ZZ);
      for (int i = 0; i < 30; i++) drive(rnd128(), rnd128(), 1'($urandom_range(0, 1)));

      // Reset for two clocks with blocks in flight.
      rst = 1'b1;
      drive(rnd128(), rnd128(), 1'b1);
      drive(rnd128(), rnd128(), 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(rnd128(), rnd128(), 1'b0);
      for (int i = 0; i < 20; i++) drive(rnd128(), rnd128(), 1'($urandom_range(0, 1)));

      // Hold one vector steady.
      for (int i = 0; i < 30; i++) drive_kat(K_AB, P_AB, C_AB);
      for (int i = 0; i < 12; i++) drive(rnd128(), rnd128(), 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
